// File: rtl/uart_rx_monitor.sv
// Simulation-side 8N1 UART receiver: synchronizes rxd, recovers bytes with a
// mid-bit sampling counter and queues them in a small FIFO with sticky error flags.
module uart_rx_monitor #(
  parameter  int CLKS_PER_BIT = 174,
  parameter  int FIFO_DEPTH   = 8,
  localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          rxd,
  input  logic          enable,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [CW-1:0] fifo_count,
  output logic          busy,
  output logic          frame_err,
  output logic          overflow,
  input  logic          clear_errors,
  output logic [2:0]    dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  logic             r_sync1, r_rxs, r_hist;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             w_cnt_clr, w_bit_en, w_push, w_ferr_set;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_frame_err, r_overflow;
  logic             w_full, w_pop, w_wr, w_ovf_set;

  // rxd is asynchronous: two flops to resolve metastability, a third for edge history
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxs   <= r_sync1;
      r_hist  <= r_rxs;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_bit_en   = 1'b0;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (enable && r_hist && !r_rxs) w_next = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_END) begin
          w_cnt_clr = 1'b1;
          w_next    = r_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_END) begin
          w_cnt_clr = 1'b1;
          w_bit_en  = 1'b1;
          if (r_idx == 3'd7) w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == BIT_END) begin
          w_cnt_clr = 1'b1;
          if (r_rxs) begin
            w_push = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_ferr_set = 1'b1;
            w_next     = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // a held-low line (break) must return high before a new start is accepted
        w_cnt_clr = 1'b1;
        if (r_rxs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      if (r_state == S_IDLE) r_idx <= '0;
      else if (w_bit_en)     r_idx <= r_idx + 3'd1;
      if (w_bit_en) r_shift[r_idx] <= r_rxs;
    end
  end

  // Output handshake: a byte transfers on every cycle where out_valid && out_ready;
  // out_data is the head entry, stable while out_valid is high and not accepted.
  assign out_valid = (r_count != '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = out_valid && out_ready;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // set takes priority over a simultaneous clear so no event is lost
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_ferr_set)        r_frame_err <= 1'b1;
      else if (clear_errors) r_frame_err <= 1'b0;
      if (w_ovf_set)         r_overflow  <= 1'b1;
      else if (clear_errors) r_overflow  <= 1'b0;
    end
  end

  assign out_data   = r_mem[r_rd_ptr];
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE);
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
Simulation-side UART receiver that consumes the DUT's uart_txd line in the top-level testbench and turns the serial stream into bytes. Fixed 8N1 framing, LSB first, oversampled by a clock-cycle counter. Holds received bytes in a small FIFO behind a valid/ready port, for a console printer or scoreboard. Reports framing and overflow errors as sticky flags.

Parameters:
CLKS_PER_BIT, 174, clock cycles per bit (20 MHz / 115200, rounded); must be >= 4
FIFO_DEPTH, 8, output FIFO entries; power of 2, >= 2
CW, $clog2(FIFO_DEPTH)+1, width of fifo_count (derived localparam, not overridable)

Ports:
clock  in  1  single clock for all logic
reset_n  in  1  asynchronous active-low reset
rxd  in  1  serial input, wired to DUT uart_txd; asynchronous to clock
enable  in  1  gates start-bit detection only
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head byte when out_valid && out_ready
out_data  out  8  FIFO head byte
fifo_count  out  CW  current occupancy, 0..FIFO_DEPTH
busy  out  1  FSM not in IDLE
frame_err  out  1  sticky: stop bit sampled low
overflow  out  1  sticky: byte dropped because FIFO full
clear_errors  in  1  clears both sticky flags

Behaviour:
- Reset (async assert, sync deassert): synchronizer flops = 1, FSM = IDLE, counters 0, FIFO empty, out_valid = 0, out_data = 0, fifo_count = 0, busy = 0, frame_err = 0, overflow = 0.
- rxd passes through a 2-flop synchronizer, plus one history flop for edge detection. All FSM decisions use the synchronized value rxs.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. busy = (state != IDLE).
- IDLE: when enable && history == 1 && rxs == 0, go to START and clear the bit counter.
- START: at count == CLKS_PER_BIT/2 - 1 (integer division), sample rxs.
  - rxs == 1: false start; return to IDLE with no flag.
  - rxs == 0: go to DATA; counter = 0, bit index = 0.
- DATA: at count == CLKS_PER_BIT - 1, shift rxs into bit[index] (LSB first) and reset the counter. After bit 7 is sampled, go to STOP.
- STOP: at count == CLKS_PER_BIT - 1, sample rxs.
  - rxs == 1: push the byte; return to IDLE.
  - rxs == 0: no push; set frame_err; go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs == 1, then go to IDLE. This absorbs a break condition without spurious starts.
- enable deasserted mid-frame: the current frame completes normally; only new starts are blocked.
- FIFO write occurs on the stop-sample cycle.
  - out_valid and the new fifo_count are visible the following cycle.
  - out_data is the registered entry at the read pointer; no extra read latency.
- Pop on any cycle with out_valid && out_ready.
- Push while full:
  - With a pop in the same cycle: the push is accepted and fifo_count is unchanged.
  - Without a pop: the byte is dropped and overflow is set.
- Push and pop on a non-full, non-empty FIFO: fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Ordering is strictly FIFO.
- Sticky flags: clear_errors clears them next cycle. If a set event and clear_errors occur in the same cycle, set wins.
- Reset mid-frame: everything returns to reset values immediately and FIFO contents are discarded. The first falling edge after release starts a fresh frame.

Test Plan:
- CLKS_PER_BIT=16, enable=1, out_ready=0; send 0x55 8N1 -> one cycle after the stop sample: out_valid=1, out_data=0x55, fifo_count=1. Pulse out_ready for 1 cycle -> out_valid=0, fifo_count=0, frame_err=0.
- Drive rxd low for 4 cycles then high -> FSM returns to IDLE after the start mid-sample; no push, no flags, busy=0.
- Send 0xA5 with stop bit held low for 3 bit times -> no push, frame_err=1, busy stays 1 until rxd high. clear_errors pulse -> frame_err=0.
- out_ready=0; send bytes 0x00..0x08 -> fifo_count=8, overflow=1. Then drain -> 0x00..0x07 in order, 0x08 lost.
- FIFO full, out_ready=1 exactly on the stop-sample cycle of byte 0x09 -> byte accepted, fifo_count stays 8, overflow unchanged. 0x09 is read out last.
- Assert reset_n low in the middle of data bit 3, release, send 0x3C -> all outputs at reset values during reset; afterwards out_data=0x3C, fifo_count=1, no flags.
